// File: rtl/pwd_lock_fsm.sv
// pwd_lock_fsm: parametrised password-entry lock controller.
// Collects NUM_DIGITS digits of DIGIT_W bits, one per rising edge of key,
// compares them against a stored password and unlocks on a match. After
// MAX_TRIES consecutive failures it enters a LOCK_CYCLES-long lockout. While
// unlocked, a press with set_mode high enters SET, where a new password is
// keyed in.
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   key           - press level (debounced upstream); one digit per rising edge
//   sw_in         - digit value sampled on a press
//   set_mode      - on the press that leaves UNLOCKED, select SET
//   clear         - abort entry / relock / abort SET
//   data_f, count - digits entered so far (newest in LSBs) and how many
//   tries_left    - remaining attempts before lockout
//   unlocked, fail, locked_out - status (fail is a one-cycle pulse)
//   h0, h1        - active-low 7-seg (gfedcba) of count and tries_left
module pwd_lock_fsm #(
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned NUM_DIGITS  = 3,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] PWD_DEFAULT = 12'h123
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                key,
  input  logic [DIGIT_W-1:0]                  sw_in,
  input  logic                                set_mode,
  input  logic                                clear,
  output logic [DIGIT_W*NUM_DIGITS-1:0]       data_f,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     count,
  output logic [$clog2(MAX_TRIES+1)-1:0]      tries_left,
  output logic                                unlocked,
  output logic                                fail,
  output logic                                locked_out,
  output logic [6:0]                          h0,
  output logic [6:0]                          h1
);

  localparam int unsigned DW = DIGIT_W * NUM_DIGITS;
  localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);
  localparam int unsigned LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_ENTRY    = 3'd0,
    ST_CHECK    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_SET      = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  state_t          state, state_n;
  logic            key_q;
  logic            press;
  logic [DW-1:0]   pwd_reg, pwd_n;
  logic [DW-1:0]   data_n;
  logic [DW-1:0]   data_shift;
  logic [CW-1:0]   count_n;
  logic [TW-1:0]   tries_n;
  logic [LW-1:0]   lock_cnt, lock_n;
  logic            fail_n;
  logic            last_digit;

  // Active-low hex decoder, segment order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Rising edge of key; a held key yields a single press.
  assign press = key & ~key_q;

  // Truncating cast keeps the low DW bits, so this also works for NUM_DIGITS == 1.
  assign data_shift = DW'({data_f, sw_in});

  // True when the current press completes the entry.
  assign last_digit = (count == CW'(NUM_DIGITS - 1));

  // Next-state and next-value logic for every register.
  always_comb begin
    state_n = state;
    data_n  = data_f;
    count_n = count;
    tries_n = tries_left;
    pwd_n   = pwd_reg;
    lock_n  = lock_cnt;
    fail_n  = 1'b0;

    case (state)
      ST_ENTRY: begin
        if (clear) begin
          data_n  = '0;
          count_n = '0;
        end else if (press) begin
          data_n  = data_shift;
          count_n = count + CW'(1);
          if (last_digit) begin
            state_n = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        data_n  = '0;
        count_n = '0;
        if (data_f == pwd_reg) begin
          state_n = ST_UNLOCKED;
          tries_n = TW'(MAX_TRIES);
        end else begin
          fail_n  = 1'b1;
          tries_n = tries_left - TW'(1);
          if (tries_left == TW'(1)) begin
            state_n = ST_LOCKOUT;
            lock_n  = LW'(LOCK_CYCLES - 1);
          end else begin
            state_n = ST_ENTRY;
          end
        end
      end

      ST_UNLOCKED: begin
        if (clear) begin
          state_n = ST_ENTRY;
        end else if (press && set_mode) begin
          state_n = ST_SET;
        end
      end

      ST_SET: begin
        if (clear) begin
          data_n  = '0;
          count_n = '0;
          state_n = ST_UNLOCKED;
        end else if (press) begin
          if (last_digit) begin
            pwd_n   = data_shift;
            data_n  = '0;
            count_n = '0;
            state_n = ST_ENTRY;
          end else begin
            data_n  = data_shift;
            count_n = count + CW'(1);
          end
        end
      end

      ST_LOCKOUT: begin
        if (lock_cnt == '0) begin
          state_n = ST_ENTRY;
          tries_n = TW'(MAX_TRIES);
        end else begin
          lock_n = lock_cnt - LW'(1);
        end
      end

      default: begin
        state_n = ST_ENTRY;
      end
    endcase
  end

  // State and output registers; status and displays follow the next values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ENTRY;
      key_q      <= 1'b0;
      data_f     <= '0;
      count      <= '0;
      tries_left <= TW'(MAX_TRIES);
      pwd_reg    <= PWD_DEFAULT;
      lock_cnt   <= '0;
      unlocked   <= 1'b0;
      fail       <= 1'b0;
      locked_out <= 1'b0;
      h0         <= 7'b1000000;
      h1         <= seg7(4'(MAX_TRIES));
    end else begin
      state      <= state_n;
      key_q      <= key;
      data_f     <= data_n;
      count      <= count_n;
      tries_left <= tries_n;
      pwd_reg    <= pwd_n;
      lock_cnt   <= lock_n;
      unlocked   <= (state_n == ST_UNLOCKED) || (state_n == ST_SET);
      fail       <= fail_n;
      locked_out <= (state_n == ST_LOCKOUT);
      h0         <= seg7(4'(count_n));
      h1         <= seg7(4'(tries_n));
    end
  end

endmodule

// File: tb/tb_pwd_lock_fsm.sv
module tb_pwd_lock_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key = 1'b0;
  logic [3:0]  sw_in = 4'h0;
  logic        set_mode = 1'b0;
  logic        clear = 1'b0;

  logic [11:0] data_f;
  logic [1:0]  count;
  logic [1:0]  tries_left;
  logic        unlocked, fail, locked_out;
  logic [6:0]  h0, h1;

  logic [15:0] b_data_f;
  logic [2:0]  b_count;
  logic [1:0]  b_tries_left;
  logic        b_unlocked, b_fail, b_locked_out;
  logic [6:0]  b_h0, b_h1;

  int checks = 0;
  int failures = 0;
  int fail_cnt = 0;
  int lock_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  pwd_lock_fsm u_dut (
    .clk(clk), .rst(rst), .key(key), .sw_in(sw_in), .set_mode(set_mode),
    .clear(clear), .data_f(data_f), .count(count), .tries_left(tries_left),
    .unlocked(unlocked), .fail(fail), .locked_out(locked_out), .h0(h0), .h1(h1)
  );

  pwd_lock_fsm #(
    .DIGIT_W(4), .NUM_DIGITS(4), .MAX_TRIES(3), .LOCK_CYCLES(16),
    .PWD_DEFAULT(16'hBEEF)
  ) u_dut4 (
    .clk(clk), .rst(rst), .key(key), .sw_in(sw_in), .set_mode(set_mode),
    .clear(clear), .data_f(b_data_f), .count(b_count), .tries_left(b_tries_left),
    .unlocked(b_unlocked), .fail(b_fail), .locked_out(b_locked_out),
    .h0(b_h0), .h1(b_h1)
  );

  // Pulse/level monitors sampled on the falling edge.
  always @(negedge clk) begin
    if (fail) fail_cnt++;
    if (locked_out) lock_cnt++;
    if (fail && unlocked) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called right after a falling edge; key high 2 cycles, low 2 cycles.
  task automatic press(input logic [3:0] d);
    sw_in = d;
    key = 1'b1;
    @(negedge clk);
    @(negedge clk);
    key = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_data", 32'(data_f), 32'h0);
    chk("rst_tries", 32'(tries_left), 32'd3);
    chk("rst_status", 32'({unlocked, fail, locked_out}), 32'b000);
    chk("rst_h0", 32'(h0), 32'b1000000);
    chk("rst_h1", 32'(h1), 32'b0110000);

    // Correct password with latency check on the last digit
    press(4'h1);
    chk("p1_count", 32'(count), 32'd1);
    chk("p1_h0", 32'(h0), 32'b1111001);
    press(4'h2);
    chk("p2_count", 32'(count), 32'd2);
    chk("p2_data", 32'(data_f), 32'h012);
    sw_in = 4'h3;
    key = 1'b1;
    @(negedge clk);
    chk("p3_count", 32'(count), 32'd3);
    chk("p3_data", 32'(data_f), 32'h123);
    chk("p3_not_yet", 32'(unlocked), 32'd0);
    @(negedge clk);
    key = 1'b0;
    chk("p3_unlocked", 32'(unlocked), 32'd1);
    chk("p3_fail", 32'(fail), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("unl_tries", 32'(tries_left), 32'd3);
    chk("unl_h0", 32'(h0), 32'b1000000);

    // Relock, then three wrong attempts
    pulse_clear();
    chk("relock", 32'(unlocked), 32'd0);
    press(4'h4); press(4'h4); press(4'h4);
    chk("w1_fail", 32'(fail_cnt), 32'd1);
    chk("w1_tries", 32'(tries_left), 32'd2);
    chk("w1_h1", 32'(h1), 32'b0100100);
    press(4'h4); press(4'h4); press(4'h4);
    chk("w2_fail", 32'(fail_cnt), 32'd2);
    chk("w2_tries", 32'(tries_left), 32'd1);
    press(4'h4); press(4'h4); press(4'h4);
    chk("w3_fail", 32'(fail_cnt), 32'd3);
    chk("w3_tries", 32'(tries_left), 32'd0);
    chk("w3_locked", 32'(locked_out), 32'd1);
    chk("w3_h1", 32'(h1), 32'b1000000);
    press(4'h5); press(4'h5);
    chk("lo_count", 32'(count), 32'd0);
    chk("lo_still", 32'(locked_out), 32'd1);
    for (int i = 0; i < 40 && locked_out; i++) @(negedge clk);
    chk("lo_ended", 32'(locked_out), 32'd0);
    chk("lo_len", 32'(lock_cnt), 32'd16);
    chk("lo_tries", 32'(tries_left), 32'd3);

    // Held key counts once
    sw_in = 4'h5;
    key = 1'b1;
    repeat (10) @(negedge clk);
    key = 1'b0;
    @(negedge clk);
    chk("hold_count", 32'(count), 32'd1);
    chk("hold_data", 32'(data_f), 32'h005);
    pulse_clear();
    chk("hold_clr", 32'(count), 32'd0);

    // Unlock, change password to 789
    press(4'h1); press(4'h2); press(4'h3);
    chk("u2_unl", 32'(unlocked), 32'd1);
    set_mode = 1'b1;
    press(4'h9);
    set_mode = 1'b0;
    chk("set_unl", 32'(unlocked), 32'd1);
    chk("set_count", 32'(count), 32'd0);
    press(4'h7); press(4'h8);
    chk("set_data", 32'(data_f), 32'h078);
    press(4'h9);
    chk("set_done", 32'(unlocked), 32'd0);
    chk("set_cnt0", 32'(count), 32'd0);
    press(4'h1); press(4'h2); press(4'h3);
    chk("old_fail", 32'(fail_cnt), 32'd4);
    chk("old_tries", 32'(tries_left), 32'd2);
    chk("old_locked", 32'(unlocked), 32'd0);
    press(4'h7); press(4'h8); press(4'h9);
    chk("new_unl", 32'(unlocked), 32'd1);
    chk("new_tries", 32'(tries_left), 32'd3);

    // Clear mid-entry, then clear with simultaneous press
    pulse_clear();
    press(4'h7); press(4'h8);
    pulse_clear();
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_data", 32'(data_f), 32'h0);
    chk("clr_tries", 32'(tries_left), 32'd3);
    press(4'h7); press(4'h8); press(4'h9);
    chk("clr_unl", 32'(unlocked), 32'd1);
    pulse_clear();
    clear = 1'b1;
    key = 1'b1;
    sw_in = 4'h4;
    @(negedge clk);
    clear = 1'b0;
    key = 1'b0;
    @(negedge clk);
    chk("clr_press", 32'(count), 32'd0);

    // Reset mid-entry restores default password
    press(4'h7);
    chk("mid_count", 32'(count), 32'd1);
    do_reset();
    chk("mid_rst", 32'(count), 32'd0);
    press(4'h1); press(4'h2); press(4'h3);
    chk("mid_unl", 32'(unlocked), 32'd1);

    // Four-digit instance with default BEEF
    do_reset();
    chk("b_rst", 32'(b_count), 32'd0);
    press(4'hB); press(4'hE); press(4'hE);
    chk("b_count", 32'(b_count), 32'd3);
    chk("b_data", 32'(b_data_f), 32'h0BEE);
    press(4'hF);
    chk("b_unl", 32'(b_unlocked), 32'd1);
    chk("b_fail", 32'(b_fail), 32'd0);

    chk("fail_and_unl", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
